// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-busy scoreboard: register file geometry
// and the long-latency producer classes that the decoder maps onto ID_isLong.
package reg_scoreboard_pkg;

  localparam int REG_NUM = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 32;

  typedef logic [RADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    LP_NONE,
    LP_LOAD,
    LP_MULDIV,
    LP_CP0
  } lp_class_t;

  // Any class other than LP_NONE produces its result too late to forward.
  function automatic logic is_long(input lp_class_t lp);
    return lp != LP_NONE;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID/WB/flush inputs and stall/bubble/debug outputs of the scoreboard.
// The master side belongs to the pipeline; the slave side belongs to the scoreboard.
interface reg_scoreboard_if #(
  parameter int REG_NUM = reg_scoreboard_pkg::REG_NUM,
  parameter int RADDR_W = reg_scoreboard_pkg::RADDR_W,
  parameter int CNT_W   = reg_scoreboard_pkg::CNT_W
);
  logic [RADDR_W-1:0] ID_rs;
  logic [RADDR_W-1:0] ID_rt;
  logic [1:0]         ID_rsrtRead;
  logic [RADDR_W-1:0] ID_rd;
  logic               ID_regWrite;
  logic               ID_isLong;
  logic               ID_valid;
  logic               EXE_ready;
  logic               WB_valid;
  logic [RADDR_W-1:0] WB_rd;
  logic               Flush;
  logic               IF_PCWr;
  logic               IF_IDWr;
  logic               IDEXE_Flush;
  logic [REG_NUM-1:0] busy_vec;
  logic [RADDR_W:0]   busy_cnt;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output ID_rs, ID_rt, ID_rsrtRead, ID_rd, ID_regWrite, ID_isLong, ID_valid,
    output EXE_ready, WB_valid, WB_rd, Flush,
    input  IF_PCWr, IF_IDWr, IDEXE_Flush, busy_vec, busy_cnt, stall_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_rsrtRead, ID_rd, ID_regWrite, ID_isLong, ID_valid,
    input  EXE_ready, WB_valid, WB_rd, Flush,
    output IF_PCWr, IF_IDWr, IDEXE_Flush, busy_vec, busy_cnt, stall_cnt
  );

endinterface

// File: rtl/reg_scoreboard_sb_popcount.sv
// Combinational population count.
// The scoreboard uses it to keep busy_cnt in step with the next busy bitmap.
module sb_popcount #(
  parameter int N = 32,
  parameter int W = 6
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard for long-latency producers (loads, mul/div, mfc0).
// It holds ID on RAW/WAW against a pending result and releases ID on the writeback cycle.
module reg_scoreboard #(
  parameter int REG_NUM = reg_scoreboard_pkg::REG_NUM,
  parameter int RADDR_W = reg_scoreboard_pkg::RADDR_W,
  parameter int CNT_W   = reg_scoreboard_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            resetn,
  reg_scoreboard_if.slave sb
);
  import reg_scoreboard_pkg::*;

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] wb_mask;
  logic [REG_NUM-1:0] set_mask;
  logic [REG_NUM-1:0] eff_busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic [RADDR_W:0]   cnt_nxt;
  logic [RADDR_W:0]   cnt_q;
  logic [CNT_W-1:0]   stall_q;
  logic               haz;
  logic               issue;

  // The regfile is write-first, so a writeback releases consumers in its own cycle.
  always_comb begin
    wb_mask = '0;
    if (sb.WB_valid) begin
      wb_mask[sb.WB_rd] = 1'b1;
    end
    eff_busy    = busy_q & ~wb_mask;
    eff_busy[0] = 1'b0;

    haz = sb.ID_valid & ((sb.ID_rsrtRead[1] & eff_busy[sb.ID_rs]) |
                         (sb.ID_rsrtRead[0] & eff_busy[sb.ID_rt]) |
                         (sb.ID_regWrite    & eff_busy[sb.ID_rd]));
    issue = sb.ID_valid & sb.EXE_ready & ~haz & ~sb.Flush;

    set_mask = '0;
    if (issue && sb.ID_regWrite && sb.ID_isLong && (sb.ID_rd != '0)) begin
      set_mask[sb.ID_rd] = 1'b1;
    end

    // A flush kills every issued long producer, so any WB this cycle is moot.
    busy_nxt = sb.Flush ? '0 : (eff_busy | set_mask);
  end

  // The pipeline flush logic owns the stage registers in a flush cycle.
  always_comb begin
    sb.IF_PCWr     = 1'b1;
    sb.IF_IDWr     = 1'b1;
    sb.IDEXE_Flush = 1'b0;
    if (!sb.Flush && haz) begin
      sb.IF_PCWr     = 1'b0;
      sb.IF_IDWr     = 1'b0;
      sb.IDEXE_Flush = 1'b1;
    end
  end

  sb_popcount #(
    .N (REG_NUM),
    .W (RADDR_W + 1)
  ) u_popcount (
    .bits  (busy_nxt),
    .count (cnt_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_nxt;
      if (haz && !sb.Flush && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign sb.busy_vec  = busy_q;
  assign sb.busy_cnt  = cnt_q;
  assign sb.stall_cnt = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard-driven bench for reg_scoreboard: a behavioural model queues expectations each cycle.
// A second instance with a narrow stall counter exercises saturation.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.REG_NUM(32), .RADDR_W(5), .CNT_W(32)) sb ();
  reg_scoreboard_if #(.REG_NUM(32), .RADDR_W(5), .CNT_W(4))  sat ();

  reg_scoreboard #(.REG_NUM(32), .RADDR_W(5), .CNT_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb)
  );

  reg_scoreboard #(.REG_NUM(32), .RADDR_W(5), .CNT_W(4)) dut_sat (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sat)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rr;
    logic [4:0] rd;
    logic       rw;
    logic       il;
    logic       er;
    logic       wbv;
    logic [4:0] wbrd;
    logic       fl;
  } stim_t;

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] busy;
    logic [5:0]  cnt;
    logic [31:0] stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  sat_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_busy = '0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_busy_n;
  logic [31:0] m_stall_n;
  exp_t        e;

  function automatic stim_t mk(input int v, input int rs, input int rt, input int rr,
                               input int rd, input int rw, input int il, input int er,
                               input int wbv, input int wbrd, input int fl);
    stim_t s;
    s.v = 1'(v);   s.rs = 5'(rs); s.rt = 5'(rt);   s.rr = 2'(rr);
    s.rd = 5'(rd); s.rw = 1'(rw); s.il = 1'(il);   s.er = 1'(er);
    s.wbv = 1'(wbv); s.wbrd = 5'(wbrd); s.fl = 1'(fl);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    sb.ID_valid = s.v;   sb.ID_rs = s.rs;     sb.ID_rt = s.rt;
    sb.ID_rsrtRead = s.rr; sb.ID_rd = s.rd;   sb.ID_regWrite = s.rw;
    sb.ID_isLong = s.il; sb.EXE_ready = s.er; sb.WB_valid = s.wbv;
    sb.WB_rd = s.wbrd;   sb.Flush = s.fl;
  endtask

  // Expectation for the current cycle is queued; the model's next state is staged for tick().
  task automatic step();
    logic [31:0] eff;
    logic        h;
    logic        iss;
    exp_t        x;
    eff = m_busy;
    if (sb.WB_valid) eff[sb.WB_rd] = 1'b0;
    h = sb.ID_valid & ((sb.ID_rsrtRead[1] & eff[sb.ID_rs]) |
                       (sb.ID_rsrtRead[0] & eff[sb.ID_rt]) |
                       (sb.ID_regWrite & eff[sb.ID_rd]));
    x.ctl   = (h && !sb.Flush) ? 3'b001 : 3'b110;
    x.busy  = m_busy;
    x.cnt   = 6'($countones(m_busy));
    x.stall = m_stall;
    exp_q.push_back(x);
    iss = sb.ID_valid & sb.EXE_ready & ~h & ~sb.Flush;
    m_busy_n = sb.Flush ? 32'd0 : eff;
    if (!sb.Flush && iss && sb.ID_regWrite && sb.ID_isLong && sb.ID_rd != 5'd0)
      m_busy_n[sb.ID_rd] = 1'b1;
    m_stall_n = (h && !sb.Flush && m_stall != 32'hFFFF_FFFF) ? m_stall + 32'd1 : m_stall;
    @(negedge clk);
  endtask

  task automatic tick();
    m_busy  = m_busy_n;
    m_stall = m_stall_n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (sb.busy_vec !== 32'd0) begin bad++; $display("[TB] FAIL reset.busy got=%h want=0", sb.busy_vec); end
    total++; if (sb.busy_cnt !== 6'd0) begin bad++; $display("[TB] FAIL reset.cnt got=%0d want=0", sb.busy_cnt); end
    total++; if (sb.stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset.stall got=%0d want=0", sb.stall_cnt); end
    total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== 3'b110) begin
      bad++; $display("[TB] FAIL reset.ctl got=%b want=110", {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush});
    end
    #10;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    stim_t t[$];
    t.push_back(mk(1, 1, 0, 2, 5, 1, 1, 1, 0, 0, 0));
    repeat (3) t.push_back(mk(1, 5, 0, 2, 6, 1, 0, 1, 0, 0, 0));
    t.push_back(mk(1, 5, 0, 2, 6, 1, 0, 1, 1, 5, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); step(); e = exp_q.pop_front();
      total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== e.ctl) begin bad++; $display("[TB] FAIL load_use.ctl cyc=%0d got=%b want=%b", i, {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush}, e.ctl); end
      total++; if (sb.busy_vec !== e.busy) begin bad++; $display("[TB] FAIL load_use.busy cyc=%0d got=%h want=%h", i, sb.busy_vec, e.busy); end
      total++; if (sb.busy_cnt !== e.cnt) begin bad++; $display("[TB] FAIL load_use.cnt cyc=%0d got=%0d want=%0d", i, sb.busy_cnt, e.cnt); end
      total++; if (sb.stall_cnt !== e.stall) begin bad++; $display("[TB] FAIL load_use.stall cyc=%0d got=%0d want=%0d", i, sb.stall_cnt, e.stall); end
      tick();
    end
    total++; if (sb.busy_vec[5] !== 1'b0) begin bad++; $display("[TB] FAIL load_use.released got=%b want=0", sb.busy_vec[5]); end
    total++; if (sb.stall_cnt !== 32'd3) begin bad++; $display("[TB] FAIL load_use.stall_total got=%0d want=3", sb.stall_cnt); end
  endtask

  task automatic test_zero_reg();
    stim_t t[$];
    t.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 3, 0, 1, 0, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); step(); e = exp_q.pop_front();
      total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== e.ctl) begin bad++; $display("[TB] FAIL zero_reg.ctl cyc=%0d got=%b want=%b", i, {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush}, e.ctl); end
      total++; if (sb.busy_vec !== e.busy) begin bad++; $display("[TB] FAIL zero_reg.busy cyc=%0d got=%h want=%h", i, sb.busy_vec, e.busy); end
      total++; if (sb.busy_cnt !== e.cnt) begin bad++; $display("[TB] FAIL zero_reg.cnt cyc=%0d got=%0d want=%0d", i, sb.busy_cnt, e.cnt); end
      total++; if (sb.stall_cnt !== e.stall) begin bad++; $display("[TB] FAIL zero_reg.stall cyc=%0d got=%0d want=%0d", i, sb.stall_cnt, e.stall); end
      tick();
    end
    total++; if (sb.busy_vec !== 32'd0) begin bad++; $display("[TB] FAIL zero_reg.final got=%h want=0", sb.busy_vec); end
  endtask

  task automatic test_waw();
    stim_t t[$];
    t.push_back(mk(1, 0, 0, 0, 8, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 8, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 8, 1, 1, 1, 1, 8, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); step(); e = exp_q.pop_front();
      total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== e.ctl) begin bad++; $display("[TB] FAIL waw.ctl cyc=%0d got=%b want=%b", i, {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush}, e.ctl); end
      total++; if (sb.busy_vec !== e.busy) begin bad++; $display("[TB] FAIL waw.busy cyc=%0d got=%h want=%h", i, sb.busy_vec, e.busy); end
      total++; if (sb.busy_cnt !== e.cnt) begin bad++; $display("[TB] FAIL waw.cnt cyc=%0d got=%0d want=%0d", i, sb.busy_cnt, e.cnt); end
      total++; if (sb.stall_cnt !== e.stall) begin bad++; $display("[TB] FAIL waw.stall cyc=%0d got=%0d want=%0d", i, sb.stall_cnt, e.stall); end
      tick();
      if (i == 2) begin
        total++; if (sb.busy_vec[8] !== 1'b1) begin bad++; $display("[TB] FAIL waw.set_wins got=%b want=1", sb.busy_vec[8]); end
      end
    end
  endtask

  task automatic test_flush();
    stim_t t[$];
    t.push_back(mk(1, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 7, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 9, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 7, 0, 2, 0, 0, 0, 1, 0, 0, 1));
    t.push_back(mk(1, 7, 0, 2, 0, 0, 0, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); step(); e = exp_q.pop_front();
      total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== e.ctl) begin bad++; $display("[TB] FAIL flush.ctl cyc=%0d got=%b want=%b", i, {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush}, e.ctl); end
      total++; if (sb.busy_vec !== e.busy) begin bad++; $display("[TB] FAIL flush.busy cyc=%0d got=%h want=%h", i, sb.busy_vec, e.busy); end
      total++; if (sb.busy_cnt !== e.cnt) begin bad++; $display("[TB] FAIL flush.cnt cyc=%0d got=%0d want=%0d", i, sb.busy_cnt, e.cnt); end
      total++; if (sb.stall_cnt !== e.stall) begin bad++; $display("[TB] FAIL flush.stall cyc=%0d got=%0d want=%0d", i, sb.stall_cnt, e.stall); end
      tick();
      if (i == 2) begin
        total++; if (sb.busy_vec !== 32'h0000_0288) begin bad++; $display("[TB] FAIL flush.pre got=%h want=00000288", sb.busy_vec); end
      end
    end
    total++; if (sb.busy_cnt !== 6'd0) begin bad++; $display("[TB] FAIL flush.cnt_final got=%0d want=0", sb.busy_cnt); end
  endtask

  task automatic test_downstream();
    stim_t t[$];
    repeat (3) t.push_back(mk(1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 4, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); step(); e = exp_q.pop_front();
      total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== e.ctl) begin bad++; $display("[TB] FAIL downstream.ctl cyc=%0d got=%b want=%b", i, {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush}, e.ctl); end
      total++; if (sb.busy_vec !== e.busy) begin bad++; $display("[TB] FAIL downstream.busy cyc=%0d got=%h want=%h", i, sb.busy_vec, e.busy); end
      total++; if (sb.busy_cnt !== e.cnt) begin bad++; $display("[TB] FAIL downstream.cnt cyc=%0d got=%0d want=%0d", i, sb.busy_cnt, e.cnt); end
      total++; if (sb.stall_cnt !== e.stall) begin bad++; $display("[TB] FAIL downstream.stall cyc=%0d got=%0d want=%0d", i, sb.stall_cnt, e.stall); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    t.push_back(mk(1, 0, 0, 0, 10, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 0, 0, 0, 11, 1, 1, 1, 0, 0, 0));
    t.push_back(mk(1, 10, 11, 3, 12, 1, 0, 1, 0, 0, 0));
    t.push_back(mk(1, 10, 11, 3, 12, 1, 0, 1, 1, 10, 0));
    t.push_back(mk(1, 10, 11, 3, 12, 1, 0, 1, 1, 11, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); step(); e = exp_q.pop_front();
      total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== e.ctl) begin bad++; $display("[TB] FAIL b2b.ctl cyc=%0d got=%b want=%b", i, {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush}, e.ctl); end
      total++; if (sb.busy_vec !== e.busy) begin bad++; $display("[TB] FAIL b2b.busy cyc=%0d got=%h want=%h", i, sb.busy_vec, e.busy); end
      total++; if (sb.busy_cnt !== e.cnt) begin bad++; $display("[TB] FAIL b2b.cnt cyc=%0d got=%0d want=%0d", i, sb.busy_cnt, e.cnt); end
      total++; if (sb.stall_cnt !== e.stall) begin bad++; $display("[TB] FAIL b2b.stall cyc=%0d got=%0d want=%0d", i, sb.stall_cnt, e.stall); end
      tick();
    end
    total++; if (sb.stall_cnt !== 32'd6) begin bad++; $display("[TB] FAIL b2b.stall_total got=%0d want=6", sb.stall_cnt); end
  endtask

  task automatic test_async_reset();
    apply(mk(1, 0, 0, 0, 12, 1, 1, 1, 0, 0, 0));
    step(); e = exp_q.pop_front(); tick();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    total++; if (sb.busy_vec !== m_busy) begin bad++; $display("[TB] FAIL async.pre got=%h want=%h", sb.busy_vec, m_busy); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (sb.busy_vec !== 32'd0) begin bad++; $display("[TB] FAIL async.busy got=%h want=0", sb.busy_vec); end
    total++; if (sb.busy_cnt !== 6'd0) begin bad++; $display("[TB] FAIL async.cnt got=%0d want=0", sb.busy_cnt); end
    total++; if (sb.stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL async.stall got=%0d want=0", sb.stall_cnt); end
    total++; if ({sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush} !== 3'b110) begin
      bad++; $display("[TB] FAIL async.ctl got=%b want=110", {sb.IF_PCWr, sb.IF_IDWr, sb.IDEXE_Flush});
    end
    m_busy  = '0;
    m_stall = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    sat.ID_valid = 1'b1; sat.ID_rs = 5'd0; sat.ID_rt = 5'd0; sat.ID_rsrtRead = 2'b00;
    sat.ID_rd = 5'd5; sat.ID_regWrite = 1'b1; sat.ID_isLong = 1'b1; sat.EXE_ready = 1'b1;
    @(posedge clk);
    #1;
    sat.ID_rs = 5'd5; sat.ID_rsrtRead = 2'b10; sat.ID_rd = 5'd6; sat.ID_isLong = 1'b0;
    for (int j = 0; j < 20; j++) begin
      sat_q.push_back((j > 15) ? 4'hF : 4'(j));
      @(negedge clk);
      want = sat_q.pop_front();
      total++; if (sat.stall_cnt !== want) begin bad++; $display("[TB] FAIL sat.stall cyc=%0d got=%0d want=%0d", j, sat.stall_cnt, want); end
      total++; if (sat.IF_PCWr !== 1'b0) begin bad++; $display("[TB] FAIL sat.hold cyc=%0d got=%b want=0", j, sat.IF_PCWr); end
      @(posedge clk);
      #1;
    end
    total++; if (sat.stall_cnt !== 4'hF) begin bad++; $display("[TB] FAIL sat.final got=%h want=f", sat.stall_cnt); end
    sat.ID_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    sat.ID_valid = 1'b0; sat.ID_rs = '0; sat.ID_rt = '0; sat.ID_rsrtRead = '0;
    sat.ID_rd = '0; sat.ID_regWrite = 1'b0; sat.ID_isLong = 1'b0; sat.EXE_ready = 1'b1;
    sat.WB_valid = 1'b0; sat.WB_rd = '0; sat.Flush = 1'b0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_waw();
    test_flush();
    test_downstream();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-busy scoreboard for the in-order single-issue pipeline.
- It tracks destination registers of long-latency producers: loads, mul/div and mfc0 results that are not forwardable before writeback.
- A producer's bit is set when the instruction issues out of ID and cleared when its result writes back.
- It generates the IF/ID stall and ID/EXE bubble controls for any instruction in ID that reads or overwrites a pending register. It is the producer-side complement of the per-cycle load-use detector.

Parameters:
REG_NUM, 32, number of architectural GPRs
RADDR_W, 5, register address width
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
ID_rs  in  RADDR_W  source register rs of instruction in ID
ID_rt  in  RADDR_W  source register rt of instruction in ID
ID_rsrtRead  in  2  [1]=rs actually read, [0]=rt actually read
ID_rd  in  RADDR_W  destination register of instruction in ID
ID_regWrite  in  1  ID instruction writes a GPR
ID_isLong  in  1  ID instruction is a long-latency producer
ID_valid  in  1  ID holds a valid instruction
EXE_ready  in  1  ID/EXE register can accept this cycle (downstream not stalled)
WB_valid  in  1  writeback of a long-latency result this cycle
WB_rd  in  RADDR_W  destination of that writeback
Flush  in  1  exception/eret flush of ID..MEM
IF_PCWr  out  1  PC write enable (0 = hold)
IF_IDWr  out  1  IF/ID write enable (0 = hold)
IDEXE_Flush  out  1  insert bubble into ID/EXE
busy_vec  out  REG_NUM  registered busy bitmap (debug)
busy_cnt  out  RADDR_W+1  number of set busy bits
stall_cnt  out  CNT_W  cycles with a scoreboard stall

Behaviour:
- Reset (resetn=0, asynchronous): busy_vec=0, busy_cnt=0, stall_cnt=0. IF_PCWr=1, IF_IDWr=1, IDEXE_Flush=0.
- Effective busy, combinational: eff_busy = busy_vec with bit WB_rd cleared when WB_valid. The regfile is write-first, so a same-cycle writeback releases consumers.
- Hazard, combinational:
  - haz = ID_valid & ( (ID_rsrtRead[1] & eff_busy[ID_rs]) | (ID_rsrtRead[0] & eff_busy[ID_rt]) | (ID_regWrite & eff_busy[ID_rd]) ).
  - The rd term is the WAW check and guarantees at most one pending producer per register.
  - Index 0 is never busy, so a reference to $0 never stalls.
- Outputs on hazard: haz=1 gives IF_PCWr=0, IF_IDWr=0, IDEXE_Flush=1. Otherwise IF_PCWr=1, IF_IDWr=1, IDEXE_Flush=0.
- Flush=1 forces IF_PCWr=1, IF_IDWr=1 and IDEXE_Flush=0 (the pipeline flush logic owns the stage registers that cycle).
- issue = ID_valid & EXE_ready & ~haz & ~Flush.
- Update on the clk rising edge, in priority order:
  - Flush=1: busy_vec <= 0. All issued long producers are in EXE/MEM and are killed; a WB in the same cycle is irrelevant.
  - Otherwise: clear bit WB_rd if WB_valid. Then set bit ID_rd if issue & ID_regWrite & ID_isLong & ID_rd!=0.
  - Set wins over clear on the same index. This is only reachable when WB releases the WAW stall in that cycle.
- busy_cnt is the registered popcount of the next busy_vec, so it stays consistent with busy_vec every cycle.
- stall_cnt increments by 1 in each cycle with haz=1 and Flush=0. It saturates at all-ones, with no wrap.
- WB_valid for a register that is not busy is a no-op (for example, the register was already cleared by Flush).
- WB_rd=0 has no effect.
- Latency: set is visible to the ID instruction in the next cycle. Clear is visible combinationally in the same cycle.

Decomposition:
- CPU_Defines.svh holds:
  - reg_addr_t (logic [4:0]) and REG_NUM.
  - The long-producer class enum {LP_NONE, LP_LOAD, LP_MULDIV, LP_CP0}. The decoder uses it to derive ID_isLong.
- One sub-module, sb_popcount (combinational popcount of REG_NUM bits), is natural. Everything else stays in reg_scoreboard.

Test Plan:
- Load-use hazard:
  - Stimulus: issue lw $5 (isLong, rd=5). Next cycle ID reads rs=5 with rsrtRead=2'b10.
  - Response: IF_PCWr=0, IF_IDWr=0, IDEXE_Flush=1 each cycle until WB_valid with WB_rd=5.
  - In that WB cycle the outputs return to 1/1/0, busy_vec[5] ends at 0, and stall_cnt equals the stall cycles.
- $0 reference: lw $0 then a reader of $0 -> busy_vec stays 0 and there is never a stall.
- WAW with release:
  - Stimulus: mul to $8 pending, ID instruction is a lw to $8 with rsrtRead=0. WB_valid with WB_rd=8 arrives in the same cycle as EXE_ready=1.
  - Response: no stall that cycle, busy_vec[8] stays 1 (set wins), busy_cnt unchanged.
- Flush mid-operation: busy_vec has bits 3, 7 and 9 set, then Flush=1 for one cycle -> next cycle busy_vec=0, busy_cnt=0, and a reader of $7 does not stall.
- Downstream stall: haz=0, EXE_ready=0, ID lw $4 held for 3 cycles -> busy_vec[4] is set only on the cycle EXE_ready=1.
- Reset and saturation:
  - Force stall_cnt near all-ones with a persistent hazard -> it holds at 32'hFFFFFFFF.
  - Assert resetn=0 mid-cycle -> all outputs return to their reset values immediately (asynchronous).
